// File: rtl/pc_seq_pkg.sv
// Shared encodings and helpers for the program-counter sequencer and its
// return-address stack.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    PCSEL_INC    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10,
    PCSEL_RETURN = 2'b11
  } pc_sel_e;

  // Number of bits needed to index `value` distinct items (minimum 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer, occupancy count, sticky
// overflow/underflow flags. A push when full overwrites the oldest entry.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign top_data  = mem_q[top_q];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push) begin
      top_d = top_q + 1'b1;
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d   = top_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: storage is not reset; count_q gates validity, so stale entries are never observed.
  always_ff @(posedge CLK) begin
    if (push) mem_q[top_d] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with four next-PC sources and a return-address
// stack. Define PC_REDIRECT_CNT_EN to build the saturating redirect counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 2,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic [15:0]      redirect_count
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;

  assign sel      = pc_sel_e'(pc_sel);
  assign pc       = pc_q;
  assign pc_plus  = pc_q + WIDTH'(INC);
  assign ras_push = !stall && (sel == PCSEL_JUMP) && call;
  assign ras_pop  = !stall && (sel == PCSEL_RETURN);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      unique case (sel)
        PCSEL_INC:    pc_d = pc_plus;
        PCSEL_BRANCH: pc_d = branch_target;
        PCSEL_JUMP:   pc_d = jump_target;
        PCSEL_RETURN: pc_d = ras_empty ? pc_plus : ras_top;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_d;
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // An empty-stack return still counts as a redirect attempt.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall && (sel != PCSEL_INC) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign redirect_count = cnt_q;
`else
  assign redirect_count = 16'h0000;
`endif

endmodule
